dmem_responder: RTL and testbench

Data-memory responder serving the load/store requests issued by the pipeline MEM stage. It accepts one request at a time over a valid/ready handshake and applies RV32I byte/half/word lane rules from funct3. It returns the load data sign- or zero-extended to 32 bits after a fixed, parameterised latency, and flags misaligned or illegal accesses. It replaces the single-cycle data memory so that MEM-stage stall logic can be exercised against a multi-cycle memory.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_lane_align.sv | 83 ++++++++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared funct3 encodings, FSM state type and captured-request
//                record for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Address is held at full 32-bit width so any DM_ADDRESS up to 32 fits.
    typedef struct packed {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational RV32I byte/half/word lane steering, load
//                extension and misaligned/illegal access detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = 32'h0;
        o_err   = 1'b0;
        if (i_we && i_re) begin
            o_err = 1'b1;
        end else if (i_we) begin
            case (i_funct3)
                F3_B: begin
                    o_be    = 4'b0001 << i_lane;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_err   = i_lane[0];
                    o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                F3_W: begin
                    o_err   = (i_lane != 2'b00);
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
                default: o_err = 1'b1;
            endcase
        end else if (i_re) begin
            case (i_funct3)
                F3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
                F3_BU: o_rdata = {24'h0, w_byte};
                F3_H: begin
                    o_err   = i_lane[0];
                    o_rdata = {{16{w_half[15]}}, w_half};
                end
                F3_HU: begin
                    o_err   = i_lane[0];
                    o_rdata = {16'h0, w_half};
                end
                F3_W: begin
                    o_err   = (i_lane != 2'b00);
                    o_rdata = i_rword;
                end
                default: o_err = 1'b1;
            endcase
        end
        if (o_err) begin
            o_be    = 4'b0000;
            o_rdata = 32'h0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data memory for the MEM stage: valid/ready request,
//                fixed-latency registered response, RV32I lane rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_re,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t               r_state;
    logic [3:0]           r_cnt;
    dmem_req_t            r_req;
    logic [31:0]          r_mem [DEPTH_WORDS];
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_req_ready;
    logic                 r_busy;

    dmem_req_t            w_live;
    dmem_req_t            w_src;
    logic                 w_accept;
    logic                 w_go_resp;
    logic                 w_commit;
    logic [DM_ADDRESS-3:0] w_word;
    logic [c_IDX_W-1:0]   w_idx;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata_sh;
    logic [31:0]          w_rdata_ext;
    logic                 w_err;
    logic                 w_unused;

    assign w_live = '{we: req_we, re: req_re, addr: 32'(req_addr),
                      wdata: 32'(req_wdata), funct3: req_funct3};

    // With LATENCY=1 the access completes on the accept edge, so the live
    // request must feed the datapath while still in IDLE.
    assign w_src    = (r_state == IDLE) ? w_live : r_req;
    assign w_accept = req_valid && r_req_ready && (req_we || req_re);

    assign w_go_resp = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                       ((r_state == ACCESS) && (r_cnt == 4'd0));

    assign w_word   = w_src.addr[DM_ADDRESS-1:2];
    assign w_idx    = c_IDX_W'(32'(w_word) % DEPTH_WORDS);
    assign w_unused = ^w_src.addr;

    dmem_lane_align u_lane_align (
        .i_funct3 (w_src.funct3),
        .i_lane   (w_src.addr[1:0]),
        .i_we     (w_src.we),
        .i_re     (w_src.re),
        .i_wdata  (w_src.wdata),
        .i_rword  (r_mem[w_idx]),
        .o_be     (w_be),
        .o_wdata  (w_wdata_sh),
        .o_rdata  (w_rdata_ext),
        .o_err    (w_err)
    );

    // Gating on reset keeps an in-flight store from landing if reset arrives
    // on its commit edge.
    assign w_commit = w_go_resp && w_src.we && !w_err && !reset;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_req       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            if (w_go_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_rdata_ext;
                r_rsp_err   <= w_err;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req       <= w_live;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= ACCESS;
                            r_cnt   <= 4'(LATENCY - 2);
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = DATA_W'(r_rsp_rdata);
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench: directed table, reset/no-op/latency-1
//                sequences and randomized traffic against a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, req_re = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        q_valid = 1'b0, q_we = 1'b0, q_re = 1'b0;
    logic [8:0]  q_addr = '0;
    logic [31:0] q_wdata = '0;
    logic [2:0]  q_funct3 = '0;
    logic        q_ready, q_rsp_valid, q_rsp_err, q_busy;
    logic [31:0] q_rsp_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] model_mem [512];

    always #5 clk = ~clk;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH_WORDS(128), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_re(req_re),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH_WORDS(128), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(q_valid), .req_ready(q_ready), .req_we(q_we), .req_re(q_re),
        .req_addr(q_addr), .req_wdata(q_wdata), .req_funct3(q_funct3),
        .rsp_valid(q_rsp_valid), .rsp_rdata(q_rsp_rdata), .rsp_err(q_rsp_err), .busy(q_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction on the LATENCY=LAT instance, with handshake
    // and timing checks; returns the captured response.
    task automatic do_req(input logic we, input logic re, input logic [8:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rd, output logic er);
        bit got = 0;
        rd = 32'h0;
        er = 1'b0;
        @(negedge clk);
        req_we = we; req_re = re; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        req_valid = 1'b1;
        chk("ready_before_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_re = 1'($urandom);
        req_addr = 9'($urandom); req_wdata = $urandom; req_funct3 = 3'($urandom);
        for (int k = 1; k <= LAT + 4 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                chk("rsp_latency", k, LAT);
                chk("ready_in_resp", {31'h0, req_ready}, 32'h0);
                chk("busy_in_resp", {31'h0, busy}, 32'h1);
                rd = rsp_rdata;
                er = rsp_err;
            end else begin
                chk("ready_in_flight", {31'h0, req_ready}, 32'h0);
                chk("busy_in_flight", {31'h0, busy}, 32'h1);
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected pulse after %0d cycles", LAT);
        end
        @(negedge clk);
        chk("rsp_valid_after", {31'h0, rsp_valid}, 32'h0);
        chk("rsp_rdata_after", rsp_rdata, 32'h0);
        chk("rsp_err_after", {31'h0, rsp_err}, 32'h0);
        chk("ready_after", {31'h0, req_ready}, 32'h1);
        chk("busy_after", {31'h0, busy}, 32'h0);
    endtask

    // Reference: byte-addressed memory, size/sign derived from funct3 rules.
    task automatic ref_access(input logic we, input logic re, input logic [8:0] addr,
                              input logic [31:0] wd, input logic [2:0] f3,
                              output logic [31:0] rd, output logic er);
        int size;
        bit legal;
        longint v;
        rd = 32'h0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        er = (we && re) || !legal || ((int'(addr) % size) != 0);
        if (er) return;
        if (we) begin
            for (int i = 0; i < size; i++) model_mem[int'(addr) + i] = 8'((wd >> (8 * i)) & 32'hFF);
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(model_mem[int'(addr) + i]) << (8 * i));
            if (f3[2] == 1'b0 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            rd = 32'(v);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;

        vecs.push_back('{"sw_deadbeef",  1, 0, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0,        0});
        vecs.push_back('{"lb_013",       0, 1, 9'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 0});
        vecs.push_back('{"lbu_013",      0, 1, 9'h013, 32'h0,        3'b100, 32'h000000DE, 0});
        vecs.push_back('{"lh_010",       0, 1, 9'h010, 32'h0,        3'b001, 32'hFFFFBEEF, 0});
        vecs.push_back('{"lhu_010",      0, 1, 9'h010, 32'h0,        3'b101, 32'h0000BEEF, 0});
        vecs.push_back('{"sb_011",       1, 0, 9'h011, 32'h00000012, 3'b000, 32'h0,        0});
        vecs.push_back('{"lw_010_sb",    0, 1, 9'h010, 32'h0,        3'b010, 32'hDEAD12EF, 0});
        vecs.push_back('{"lw_misalign",  0, 1, 9'h012, 32'h0,        3'b010, 32'h0,        1});
        vecs.push_back('{"sh_misalign",  1, 0, 9'h011, 32'h0000FFFF, 3'b001, 32'h0,        1});
        vecs.push_back('{"lw_010_keep",  0, 1, 9'h010, 32'h0,        3'b010, 32'hDEAD12EF, 0});
        vecs.push_back('{"ld_f3_011",    0, 1, 9'h010, 32'h0,        3'b011, 32'h0,        1});
        vecs.push_back('{"ld_f3_110",    0, 1, 9'h010, 32'h0,        3'b110, 32'h0,        1});
        vecs.push_back('{"ld_f3_111",    0, 1, 9'h010, 32'h0,        3'b111, 32'h0,        1});
        vecs.push_back('{"st_f3_100",    1, 0, 9'h014, 32'h12345678, 3'b100, 32'h0,        1});
        vecs.push_back('{"we_and_re",    1, 1, 9'h010, 32'h0,        3'b010, 32'h0,        1});
        vecs.push_back('{"lh_012_keep",  0, 1, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 0});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
        end

        // Valid without we/re is ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_re = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("noop_busy", {31'h0, busy}, 32'h0);
            chk("noop_rsp", {31'h0, rsp_valid}, 32'h0);
            chk("noop_ready", {31'h0, req_ready}, 32'h1);
        end
        req_valid = 1'b0;

        // Reset mid-operation drops an uncommitted store
        do_req(1, 0, 9'h020, 32'h0, 3'b010, rd, er);
        chk("sw_020_err", {31'h0, er}, 32'h0);
        @(negedge clk);
        req_we = 1'b1; req_re = 1'b0; req_addr = 9'h020; req_wdata = 32'h11111111;
        req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        do_req(0, 1, 9'h020, 32'h0, 3'b010, rd, er);
        chk("lw_020_after_rst", rd, 32'h0);
        chk("lw_020_after_rst_err", {31'h0, er}, 32'h0);

        // LATENCY=1: seed a word, then hold back-to-back loads
        @(negedge clk);
        q_we = 1'b1; q_re = 1'b0; q_addr = 9'h004; q_wdata = 32'hCAFEF00D;
        q_funct3 = 3'b010; q_valid = 1'b1;
        @(posedge clk);
        #1 q_valid = 1'b0;
        @(negedge clk);
        chk("l1_sw_rsp", {31'h0, q_rsp_valid}, 32'h1);
        @(negedge clk);
        chk("l1_sw_idle", {31'h0, q_ready}, 32'h1);
        q_we = 1'b0; q_re = 1'b1; q_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("l1_rsp_valid", {31'h0, q_rsp_valid}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("l1_busy", {31'h0, q_busy}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("l1_ready", {31'h0, q_ready}, (k % 2 == 0) ? 32'h0 : 32'h1);
            chk("l1_rdata", q_rsp_rdata, (k % 2 == 0) ? 32'hCAFEF00D : 32'h0);
        end
        q_valid = 1'b0;

        // Randomized traffic over a pre-initialised region
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            ref_access(1, 0, 9'(9'h080 + 4 * w), d, 3'b010, mrd, mer);
            do_req(1, 0, 9'(9'h080 + 4 * w), d, 3'b010, rd, er);
            chk("init_err", {31'h0, er}, {31'h0, mer});
        end
        for (int n = 0; n < 200; n++) begin
            logic        we, re;
            logic [8:0]  a;
            logic [31:0] d;
            logic [2:0]  f3;
            int          r;
            r  = $urandom_range(0, 9);
            we = (r <= 3) || (r == 9);
            re = (r >= 4);
            a  = 9'(9'h080 + $urandom_range(0, 63));
            d  = $urandom;
            f3 = (($urandom_range(0, 3) == 0)) ? 3'($urandom_range(0, 7))
                                                : ((r <= 3) ? 3'($urandom_range(0, 2))
                                                            : 3'($urandom_range(0, 5)));
            ref_access(we, re, a, d, f3, mrd, mer);
            do_req(we, re, a, d, f3, rd, er);
            chk("rand_rdata", rd, mrd);
            chk("rand_err", {31'h0, er}, {31'h0, mer});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
